// File: rtl/weight_tile_fetcher.sv
// Weight tile fetcher: streams a row-major int8 matrix from word memory
// and packs it into TILE_SIZE-lane tiles for the GEMV engine.
module weight_tile_fetcher #(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_SIZE  = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int ADDR_WIDTH = 24
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 start,
   input  logic [ADDR_WIDTH-1:0]                base_addr,
   input  logic [9:0]                           rows,
   input  logic [9:0]                           cols,
   output logic                                 mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   input  logic [BUS_WIDTH-1:0]                 mem_rdata,
   input  logic                                 mem_rvalid,
   output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] w_tile_row,
   output logic                                 w_valid,
   input  logic                                 w_ready,
   output logic                                 busy,
   output logic                                 done
);

   localparam int EPW   = BUS_WIDTH / DATA_WIDTH;
   localparam int BEATS = TILE_SIZE * DATA_WIDTH / BUS_WIDTH;
   localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = 21;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_DATA,
      PRESENT,
      DONE
   } state_t;

   state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           base_q, base_d;
   logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
   logic [19:0]                     n_q, n_d;
   logic [CW-1:0]                   word_q, word_d;
   logic [CW-1:0]                   tile_q, tile_d;
   logic [BIW-1:0]                  beat_q, beat_d;
   logic [BEATS-1:0][BUS_WIDTH-1:0] buf_q, buf_d;
   logic                            rd_en_q, rd_en_d;
   logic                            valid_q, valid_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic [CW-1:0]                   n_ext, w_total, t_total, elem_idx;
   logic [BUS_WIDTH-1:0]            word_m;

   assign n_ext   = {1'b0, n_q};
   assign w_total = (n_ext + CW'(EPW - 1)) / CW'(EPW);
   assign t_total = (n_ext + CW'(TILE_SIZE - 1)) / CW'(TILE_SIZE);

   // Lanes of the incoming word that fall past the matrix end read as zero.
   always_comb begin
      word_m   = mem_rdata;
      elem_idx = '0;
      for (int k = 0; k < EPW; k++) begin
         elem_idx = word_q * CW'(EPW) + CW'(k);
         if (elem_idx >= n_ext) begin
            word_m[k*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      n_d     = n_q;
      word_d  = word_q;
      tile_d  = tile_q;
      beat_d  = beat_q;
      buf_d   = buf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_addr;
               n_d     = {10'd0, rows} * {10'd0, cols};
               word_d  = '0;
               tile_d  = '0;
               beat_d  = '0;
               buf_d   = '0;
               state_d = (rows == '0 || cols == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_d = WAIT_DATA;
         WAIT_DATA: begin
            if (mem_rvalid) begin
               buf_d[beat_q] = word_m;
               word_d        = word_q + 1'b1;
               if (beat_q == BIW'(BEATS - 1) || word_d == w_total) begin
                  state_d = PRESENT;
               end else begin
                  beat_d  = beat_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         PRESENT: begin
            if (w_ready) begin
               tile_d  = tile_q + 1'b1;
               beat_d  = '0;
               buf_d   = '0;
               state_d = (tile_d < t_total) ? FETCH : DONE;
            end
         end
         DONE: if (done_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      rd_en_d = (state_d == FETCH);
      addr_d  = rd_en_d ? base_d + ADDR_WIDTH'(word_d * CW'(BUS_WIDTH / 8))
                        : addr_q;
      valid_d = (state_d == PRESENT);
      // An empty matrix spends one DONE cycle busy before pulsing done.
      done_d  = (state_d == DONE) && (state_q != IDLE);
      busy_d  = (state_d != IDLE) && !done_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         n_q     <= '0;
         word_q  <= '0;
         tile_q  <= '0;
         beat_q  <= '0;
         buf_q   <= '0;
         rd_en_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         n_q     <= n_d;
         word_q  <= word_d;
         tile_q  <= tile_d;
         beat_q  <= beat_d;
         buf_q   <= buf_d;
         rd_en_q <= rd_en_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign mem_rd_en  = rd_en_q;
   assign mem_addr   = addr_q;
   assign w_tile_row = buf_q;
   assign w_valid    = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_weight_tile_fetcher.sv
// Bench for weight_tile_fetcher: memory responder, tile scoreboard and
// a byte-array reference model of the expected tiles and reads.
module tb_weight_tile_fetcher;

   localparam int DW = 8;
   localparam int TS = 32;
   localparam int BW = 64;
   localparam int AW = 24;
   localparam int BEATS = TS * DW / BW;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   start = 1'b0;
   logic [AW-1:0]          base_addr = '0;
   logic [9:0]             rows = '0;
   logic [9:0]             cols = '0;
   logic                   mem_rd_en;
   logic [AW-1:0]          mem_addr;
   logic [BW-1:0]          mem_rdata = '0;
   logic                   mem_rvalid = 1'b0;
   logic [TS-1:0][DW-1:0]  w_tile_row;
   logic                   w_valid;
   logic                   w_ready = 1'b0;
   logic                   busy;
   logic                   done;

   weight_tile_fetcher #(
      .DATA_WIDTH(DW), .TILE_SIZE(TS), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .base_addr(base_addr), .rows(rows), .cols(cols),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .w_tile_row(w_tile_row), .w_valid(w_valid), .w_ready(w_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [65536];

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [255:0] got,
                        input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Responder/monitor state; written only by the negedge process.
   int cyc = 0;
   int lat_mode = 0;
   int ready_mode = 0;
   bit spur = 1'b0;
   bit pend = 1'b0;
   int cnt = 0;
   int bp = 0;
   logic [AW-1:0] pend_addr = '0;
   logic [AW-1:0] rd_q[$];
   int rd_cyc[$];
   logic [255:0] xf_q[$];
   int xf_cyc[$];
   int vr_cyc[$];
   int done_cyc[$];
   int v_two = 0, v_pre = 0, v_hold = 0, v_drop = 0;
   bit hold_p = 1'b0, xfer_p = 1'b0, valid_p = 1'b0;
   logic [255:0] tile_p = '0;

   always @(negedge clk) begin
      cyc++;
      mem_rvalid = 1'b0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            pend = 1'b0;
            mem_rvalid = 1'b1;
            for (int k = 0; k < BW / 8; k++)
               mem_rdata[8*k +: 8] = mem[16'(pend_addr + AW'(k))];
         end
      end else if (spur && w_valid && $urandom_range(1, 0) == 1) begin
         mem_rvalid = 1'b1;
         mem_rdata = {$urandom, $urandom};
      end
      if (mem_rd_en) begin
         if (pend) v_two++;
         if (w_valid) v_pre++;
         pend = 1'b1;
         cnt = (lat_mode == 0) ? 1 :
               (lat_mode == 2) ? 5 : int'($urandom_range(7, 1));
         pend_addr = mem_addr;
         rd_q.push_back(mem_addr);
         rd_cyc.push_back(cyc);
      end
      if (hold_p && (!w_valid || w_tile_row != tile_p)) v_hold++;
      if (xfer_p && w_valid) v_drop++;
      if (w_valid && !valid_p) vr_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      case (ready_mode)
         0: w_ready = 1'b1;
         1: w_ready = 1'($urandom_range(1, 0));
         default: begin
            if (w_valid && bp < 10) begin
               w_ready = 1'b0;
               bp++;
            end else begin
               w_ready = 1'b1;
            end
         end
      endcase
      xfer_p = w_valid && w_ready;
      hold_p = w_valid && !w_ready;
      tile_p = w_tile_row;
      valid_p = w_valid;
      if (xfer_p) begin
         xf_q.push_back(w_tile_row);
         xf_cyc.push_back(cyc);
         bp = 0;
      end
   end

   function automatic logic [255:0] model_tile(input int base, input int n,
                                               input int t);
      logic [255:0] r = '0;
      for (int l = 0; l < TS; l++) begin
         int idx = t * TS + l;
         if (idx < n) r[8*l +: 8] = mem[base + idx];
      end
      return r;
   endfunction

   task automatic run_job(input int base, input int r, input int c,
                          input int lm, input int rm, input bit sp,
                          input bit poke, input int er, input int et);
      int n, s_rd, s_xf, s_vr, s_dn, s_two, s_pre, s_hold, s_drop, k;
      n = r * c;
      s_rd = rd_q.size();
      s_xf = xf_q.size();
      s_vr = vr_cyc.size();
      s_dn = done_cyc.size();
      s_two = v_two;
      s_pre = v_pre;
      s_hold = v_hold;
      s_drop = v_drop;
      k = 0;
      lat_mode = lm;
      ready_mode = rm;
      spur = sp;
      @(negedge clk);
      base_addr = AW'(base);
      rows = 10'(r);
      cols = 10'(c);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("rd_en_after_start", mem_rd_en, n != 0);
      if (n == 0) begin
         @(negedge clk);
         check("empty_done", done, 1);
         check("empty_busy", busy, 0);
      end
      while (done_cyc.size() == s_dn && k < 5000) begin
         @(negedge clk);
         k++;
         if (poke && k == 3 && busy) begin
            start = 1'b1;
            rows = 10'd7;
            cols = 10'd7;
            base_addr = 'h4000;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (k >= 5000) begin
         check("done_timeout", 0, 1);
         reset_n = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
      end
      repeat (3) @(negedge clk);
      check("done_count", done_cyc.size() - s_dn, 1);
      check("read_count", rd_q.size() - s_rd, er);
      for (int i = 0; i < er && s_rd + i < rd_q.size(); i++)
         check("read_addr", rd_q[s_rd + i], base + 8 * i);
      check("tile_count", xf_q.size() - s_xf, et);
      for (int i = 0; i < et && s_xf + i < xf_q.size(); i++)
         check("tile_data", xf_q[s_xf + i], model_tile(base, n, i));
      if (et > 0 && xf_q.size() > s_xf && done_cyc.size() > s_dn)
         check("done_after_xfer", done_cyc[s_dn], xf_cyc[$] + 1);
      if (lm == 0 && n >= TS && vr_cyc.size() > s_vr && rd_q.size() > s_rd)
         check("fill_latency", vr_cyc[s_vr] - rd_cyc[s_rd], 2 * BEATS);
      if (rm == 2 && et > 0 && vr_cyc.size() > s_vr && xf_q.size() > s_xf)
         check("backpressure_len", xf_cyc[s_xf] - vr_cyc[s_vr], 10);
      check("two_outstanding", v_two - s_two, 0);
      check("read_in_present", v_pre - s_pre, 0);
      check("tile_unstable", v_hold - s_hold, 0);
      check("valid_after_xfer", v_drop - s_drop, 0);
   endtask

   typedef struct {
      int base;
      int r;
      int c;
      int lm;
      int rm;
      bit sp;
      bit poke;
      int er;
      int et;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int s_rd, r, c, b, n;
      tbl[0] = '{'h100,  2,  3, 0, 0, 1'b0, 1'b0,  1, 1};
      tbl[1] = '{'h000,  4, 16, 0, 0, 1'b0, 1'b0,  8, 2};
      tbl[2] = '{'h200,  3, 11, 0, 1, 1'b0, 1'b1,  5, 2};
      tbl[3] = '{'h300,  0,  5, 0, 0, 1'b0, 1'b0,  0, 0};
      tbl[4] = '{'h400, 10, 10, 1, 1, 1'b1, 1'b1, 13, 4};
      tbl[5] = '{'h800,  5,  7, 1, 0, 1'b1, 1'b0,  5, 2};
      tbl[6] = '{'h1000, 4,  8, 0, 2, 1'b0, 1'b0,  4, 1};
      tbl[7] = '{'h1200, 2, 40, 1, 2, 1'b1, 1'b0, 10, 3};
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      repeat (3) @(negedge clk);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_valid", w_valid, 0);
      check("rst_tile", w_tile_row, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_job(tbl[i].base, tbl[i].r, tbl[i].c, tbl[i].lm, tbl[i].rm,
                 tbl[i].sp, tbl[i].poke, tbl[i].er, tbl[i].et);

      // Reset while a slow read is outstanding.
      lat_mode = 2;
      ready_mode = 0;
      spur = 1'b0;
      @(negedge clk);
      base_addr = 'h2200;
      rows = 10'd4;
      cols = 10'd16;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_rd_en", mem_rd_en, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_valid", w_valid, 0);
      check("mid_rst_tile", w_tile_row, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      s_rd = rd_q.size();
      repeat (10) @(negedge clk);
      check("late_rvalid_reads", rd_q.size() - s_rd, 0);
      check("late_rvalid_busy", busy, 0);
      run_job('h2300, 1, 1, 0, 0, 1'b0, 1'b0, 1, 1);

      for (int i = 0; i < 6; i++) begin
         r = int'($urandom_range(12, 0));
         c = int'($urandom_range(40, 1));
         b = 'h3000 + 8 * int'($urandom_range(100, 0));
         n = r * c;
         run_job(b, r, c, 1, 1, 1'b1, 1'b0, (n + 7) / 8, (n + TS - 1) / TS);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout");
      $fatal(1);
   end

endmodule
